seq_bin2bcd_ctrl: RTL
=====================

Name: seq_bin2bcd_ctrl

Overview:
- Sequential double-dabble controller: converts a BIN_W-bit unsigned binary value to DIGITS packed BCD digits over multiple cycles.
- Holds one scratch BCD register and applies the add-3 digit correction (+3 when digit ≥ 5) to all digits in a dedicated adjust cycle, then shifts.
- Sits between a binary source (counter/ALU result) and the seven-segment/display path; start/busy/done handshake.

Parameters:
- BIN_W, 8, width of binary input; legal range 1..16.
- DIGITS, 3, number of BCD output digits; integrator guarantees 10^DIGITS > 2^BIN_W - 1.

Ports:
- clk  input  1  system clock, all logic rising-edge.
- rst  input  1  synchronous active-high reset.
- start  input  1  request a conversion; sampled only in IDLE.
- bin_in  input  BIN_W  binary operand; captured on the edge that accepts start.
- busy  output  1  high in ADJ and SHIFT states.
- done  output  1  one-cycle pulse, high only in DONE state.
- bcd_out  output  4*DIGITS  registered result; digit k in bits [4k+3:4k], digit 0 = units.

Behaviour:
- Clock/reset: one clock (clk); reset rst is synchronous and active-high.
- Reset (rst=1 at an edge): state=IDLE, busy=0, done=0, bcd_out=0, scratch BCD=0, shift copy=0, counter=0. rst overrides all other inputs.
- States: IDLE, ADJ, SHIFT, DONE.
- IDLE: if start=1 at edge: bin_sh<=bin_in, scratch<=0, cnt<=BIN_W, ->ADJ. Else stay.
- ADJ: each scratch digit d: d<=(d>=5)?d+3:d, all digits in parallel, 4-bit result (values 10..15 cannot occur in legal operation; if they do, +3 wraps mod 16, no error flag). ->SHIFT.
- SHIFT: {scratch,bin_sh}<={scratch,bin_sh}<<1. Bit shifted out of the top digit is discarded. cnt<=cnt-1. If cnt==1 (last bit): bcd_out<=shifted scratch, ->DONE. Else ->ADJ.
- DONE: done=1 for exactly this cycle, then ->IDLE unconditionally.
- Latency: start accepted at edge E0; done is high in the cycle following edge E0+2*BIN_W (16 edges for BIN_W=8); bcd_out is valid from that same cycle.
- Throughput: one conversion per 2*BIN_W+2 cycles; the earliest next accept is the IDLE cycle directly after DONE.
- start while busy or in DONE: ignored, not queued; bin_in changes after acceptance have no effect.
- bcd_out holds the previous result throughout a new conversion; it changes only on the final SHIFT edge or on reset.
- Reset mid-conversion: next state IDLE, no done pulse, bcd_out cleared to 0.
- busy and done are never high simultaneously. Both are decoded from registered state, with no combinational path from inputs.
- Identical cycle count for every operand value; no early termination on leading zeros.

Test Plan:
- Reset, then start with bin_in=8'd255 -> busy high 16 cycles, done pulse 16 cycles after accept, bcd_out=12'h255.
- Conversions of 0, 9, 10, 99, 128 -> bcd_out=12'h000, 12'h009, 12'h010, 12'h099, 12'h128, one done pulse each.
- Hold start=1 continuously with bin_in=8'd42 -> accepts only in IDLE, bcd_out=12'h042, done pulse every 18 cycles, no extra conversions.
- Accept 200, then pulse start with bin_in=17 while busy -> result 12'h200, the mid-conversion request is ignored, bcd_out keeps its previous value until the final edge.
- Assert rst at cycle 5 of a conversion of 8'd77 -> state IDLE, busy=0, no done pulse, bcd_out=0; a subsequent conversion of 77 gives 12'h077.
- Exhaustive sweep 0..255 against a reference model of bin_in%10, (bin_in/10)%10, bin_in/100 -> all match, and busy/done are never high together.

Source files
------------

// File: rtl/seq_bin2bcd_ctrl.sv
// Sequential double-dabble binary-to-BCD converter with start/busy/done handshake.
// Each input bit costs two cycles: an add-3 adjust of every digit, then a one-bit shift.
module seq_bin2bcd_ctrl #(
    parameter int BIN_W  = 8,
    parameter int DIGITS = 3
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [BIN_W-1:0]      bin_in,
    output logic                  busy,
    output logic                  done,
    output logic [4*DIGITS-1:0]   bcd_out
);

    localparam int BCD_W = 4 * DIGITS;
    localparam int CNT_W = $clog2(BIN_W + 1);

    typedef enum logic [1:0] {IDLE, ADJ, SHIFT, DONE} state_t;

    state_t             state;
    logic [BCD_W-1:0]   scratch;
    logic [BCD_W-1:0]   scratchAdj;
    logic [BCD_W-1:0]   scratchSh;
    logic [BIN_W-1:0]   binSh;
    logic [CNT_W-1:0]   cnt;

    // Out-of-range digits (10..15) simply wrap mod 16; legal operands never produce them.
    for (genvar g = 0; g < DIGITS; g++) begin : gDigit
        assign scratchAdj[4*g +: 4] = (scratch[4*g +: 4] >= 4'd5) ? scratch[4*g +: 4] + 4'd3
                                                                  : scratch[4*g +: 4];
    end

    // MSB of the binary copy enters the units digit; the top BCD bit falls off.
    assign scratchSh = {scratch[BCD_W-2:0], binSh[BIN_W-1]};

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            busy    <= 1'b0;
            done    <= 1'b0;
            bcd_out <= '0;
            scratch <= '0;
            binSh   <= '0;
            cnt     <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        binSh   <= bin_in;
                        scratch <= '0;
                        cnt     <= CNT_W'(BIN_W);
                        busy    <= 1'b1;
                        state   <= ADJ;
                    end
                end
                ADJ: begin
                    scratch <= scratchAdj;
                    state   <= SHIFT;
                end
                SHIFT: begin
                    scratch <= scratchSh;
                    binSh   <= binSh << 1;
                    cnt     <= cnt - CNT_W'(1);
                    if (cnt == CNT_W'(1)) begin
                        bcd_out <= scratchSh;
                        busy    <= 1'b0;
                        done    <= 1'b1;
                        state   <= DONE;
                    end else begin
                        state <= ADJ;
                    end
                end
                DONE: begin
                    done  <= 1'b0;
                    state <= IDLE;
                end
                default: begin
                    busy  <= 1'b0;
                    done  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule
